serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Sequenced bit-serial add/subtract unit. Accepts parallel operands on a valid/ready handshake, serializes them LSB-first through a 1-bit full adder with a registered carry over W cycles, and returns the parallel result plus carry on a second valid/ready handshake. Intended as the managed front-end for serial arithmetic in area-constrained datapaths; one operation in flight at a time.

Parameters:
W, 4, operand/result width in bits; legal range W >= 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands (high only in IDLE)
op_a  input  W  operand A, sampled on input handshake
op_b  input  W  operand B, sampled on input handshake
op_sub  input  1  1 = A - B, 0 = A + B; sampled on input handshake
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
result  output  W  sum/difference, registered
cout  output  1  final carry; for subtract, 1 = no borrow (A >= B unsigned)
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=0): state IDLE; reg_a, reg_b, carry, bit counter = 0; result=0, cout=0, out_valid=0, in_ready=1 after release. Reset during SHIFT or DONE aborts the op; no result is produced.
- FSM states IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid=1 at a rising edge: reg_a<=op_a; reg_b<=op_sub ? ~op_b : op_b; carry<=op_sub; cnt<=0; go to SHIFT.
- SHIFT: in_ready=0. Each cycle: s = reg_a[0]^reg_b[0]^carry; carry <= majority(reg_a[0],reg_b[0],carry); reg_a <= {s, reg_a[W-1:1]}; reg_b <= reg_b >> 1; cnt <= cnt+1. When cnt==W-1, go to DONE. Exactly W cycles spent in SHIFT.
- DONE: out_valid=1; result=reg_a; cout=carry; both held stable until out_ready=1 at a rising edge, then go to IDLE. in_valid is ignored.
- Latency: out_valid rises exactly W clocks after the input-handshake edge. Minimum issue interval W+2 clocks (IDLE, W x SHIFT, DONE).
- Arithmetic: modulo 2^W; carry-out reported separately; op_a/op_b/op_sub changes after acceptance have no effect.
- cnt width max(1, $clog2(W)); W=1 gives a single SHIFT cycle (cnt==0 == W-1).
- out_valid and in_ready are never high in the same cycle.

Optional Feature:
SERIAL_ADD_OVF_EN: when defined, adds output port ovf (1 bit) = signed two's-complement overflow, computed as carry-in to the MSB XOR carry-out on the final SHIFT cycle. Registered, valid with out_valid, held through DONE, reset 0. When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- W=4, add a=4'h5, b=4'h3 -> result=4'h8, cout=0; out_valid exactly 4 clocks after acceptance; busy high for 5 cycles.
- W=4, add a=4'hF, b=4'h1 -> result=4'h0, cout=1 (ovf=0 with SERIAL_ADD_OVF_EN). Add a=4'h7, b=4'h1 -> result=4'h8, cout=0, ovf=1.
- W=4, sub a=4'h3, b=4'h5 -> result=4'hE, cout=0. Sub a=4'h5, b=4'h3 -> result=4'h2, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> result and cout stable, in_ready=0, no new op accepted; out_ready=1 -> IDLE on the next edge.
- Reset asserted on the 2nd SHIFT cycle -> out_valid=0 and in_ready=1 after release. The next op a=4'h2, b=4'h2 -> result=4'h4, cout=0.
- W=1: add a=1, b=1 -> result=0, cout=1, out_valid 1 clock after acceptance. Sub a=0, b=1 -> result=1, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial LSB-first add/subtract with valid/ready operand and result handshakes.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic         ovf,
`endif
    output logic         busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] reg_a, reg_b;
    logic [CW-1:0] cnt;
    logic carry, s, maj, last;
    assign s = reg_a[0] ^ reg_b[0] ^ carry;
    assign maj = (reg_a[0] & reg_b[0]) | (reg_a[0] & carry) | (reg_b[0] & carry);
    assign last = cnt == CW'(W - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign result = reg_a;
    assign cout = carry;
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
                   state == SHIFT ? (last ? DONE : SHIFT) :
                                    (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    // Sum bits enter at the MSB of reg_a, so after W shifts reg_a holds the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_a <= '0;
            reg_b <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            reg_a <= op_a;
            reg_b <= op_sub ? ~op_b : op_b;
            carry <= op_sub;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            reg_a <= (reg_a >> 1) | (W'(s) << (W - 1));
            reg_b <= reg_b >> 1;
            carry <= maj;
            cnt   <= cnt + CW'(1);
`ifdef SERIAL_ADD_OVF_EN
            if (last) ovf <= carry ^ maj;
`endif
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks of serial_add_ctrl at W=4 and W=1.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iv4 = 1'b0, or4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic ir4, ov4, c4, busy4;
    logic [3:0] r4;
    logic iv1 = 1'b0, or1 = 1'b0, sub1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic ir1, ov1, c1, busy1;
    logic [0:0] r1;
`ifdef SERIAL_ADD_OVF_EN
    logic ovf4, ovf1;
`endif
    int tests = 0, failed = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.W(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op_a(a4), .op_b(b4),
        .op_sub(sub4), .out_valid(ov4), .out_ready(or4), .result(r4), .cout(c4),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf4),
`endif
        .busy(busy4)
    );
    serial_add_ctrl #(.W(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op_a(a1), .op_b(b1),
        .op_sub(sub1), .out_valid(ov1), .out_ready(or1), .result(r1), .cout(c1),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf1),
`endif
        .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check latency/busy span/result, then drain with out_ready.
    task automatic run(input bit one, input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic sub, input logic [3:0] er, input logic ec, input logic eovf);
        int lat, nb;
        if (one) begin a1 = a[0:0]; b1 = b[0:0]; sub1 = sub; iv1 = 1'b1; end
        else begin a4 = a; b4 = b; sub4 = sub; iv4 = 1'b1; end
        step();
        iv1 = 1'b0; iv4 = 1'b0;
        a4 = ~a4; b4 = ~b4; sub4 = ~sub4;
        lat = 0; nb = 0;
        while (!(one ? ov1 : ov4) && lat < 20) begin
            if (one ? busy1 : busy4) nb++;
            chk({tag, "_iready_busy"}, 32'(one ? ir1 : ir4), 32'(0));
            step();
            lat++;
        end
        if (one ? busy1 : busy4) nb++;
        chk({tag, "_latency"}, 32'(lat), one ? 32'(1) : 32'(4));
        chk({tag, "_busy_cycles"}, 32'(nb), one ? 32'(2) : 32'(5));
        chk({tag, "_result"}, one ? 32'(r1) : 32'(r4), 32'(er));
        chk({tag, "_cout"}, 32'(one ? c1 : c4), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
        if (!one) chk({tag, "_ovf"}, 32'(ovf4), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unreachable");
`endif
        if (one) or1 = 1'b1; else or4 = 1'b1;
        step();
        or1 = 1'b0; or4 = 1'b0;
        chk({tag, "_idle_after"}, 32'({(one ? ir1 : ir4), (one ? ov1 : ov4), (one ? busy1 : busy4)}), 32'(3'b100));
    endtask

    initial begin
        #2;
        chk("rst_outputs", 32'({r4, c4, ov4, busy4}), 32'(0));
        step();
        rst = 1'b1;
        step();
        chk("post_rst_w4", 32'({ir4, ov4, busy4, c4, r4}), 32'({4'b1000, 4'h0}));
        chk("post_rst_w1", 32'({ir1, ov1, busy1, c1, r1}), 32'(5'b10000));

        run(0, "add_5_3", 4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1);
        run(0, "add_F_1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        run(0, "add_7_1", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        run(0, "sub_3_5", 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);
        run(0, "sub_5_3", 4'h5, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0);

        // Backpressure: hold DONE while hammering the input side.
        a4 = 4'h1; b4 = 4'h1; sub4 = 1'b0; iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        repeat (4) step();
        chk("bp_enter_done", 32'(ov4), 32'(1));
        for (int i = 0; i < 5; i++) begin
            iv4 = ~iv4; a4 = 4'(i * 3 + 7); b4 = 4'(i + 9); sub4 = ~sub4;
            step();
            chk("bp_hold", 32'({ov4, ir4, c4, r4}), 32'({3'b100, 4'h2}));
        end
        iv4 = 1'b0; or4 = 1'b1;
        step();
        or4 = 1'b0;
        chk("bp_release", 32'({ir4, ov4, busy4}), 32'(3'b100));

        // Reset on the second SHIFT cycle aborts the op.
        a4 = 4'h9; b4 = 4'h9; sub4 = 1'b0; iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        step();
        chk("abort_in_shift", 32'(busy4), 32'(1));
        rst = 1'b0;
        #1;
        chk("abort_async", 32'({ir4, ov4, busy4}), 32'(3'b100));
        step();
        rst = 1'b1;
        repeat (5) step();
        chk("abort_no_result", 32'({ir4, ov4, busy4}), 32'(3'b100));
        run(0, "add_2_2", 4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0);

        run(1, "w1_add_1_1", 4'h1, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        run(1, "w1_sub_0_1", 4'h0, 4'h1, 1'b1, 4'h1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
